// File: rtl/reg_pipe_pkg.sv
// reg_pipe shared constants and helpers.
// Occupancy width helper is used by the REG_PIPE_OCC_EN build.
package reg_pipe_pkg;

  localparam int REG_PIPE_MAX_WIDTH = 64;
  localparam int REG_PIPE_MAX_DEPTH = 16;

  function automatic int occ_width(
    input int depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one data+valid pipeline slot.
// Clear beats advance; otherwise the slot holds.
module reg_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             d_valid_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (en_i) begin
      data_d  = d_i;
      valid_d = d_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o       = data_q;
  assign q_valid_o = valid_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage enabled pipeline with valid tags and flush.
// Define REG_PIPE_OCC_EN to add the registered Occ occupancy port.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             D_valid,
  input  logic             En,
  input  logic             Clr,
  output logic [WIDTH-1:0] Q,
`ifdef REG_PIPE_OCC_EN
  output logic             Q_valid,
  output logic [occ_width(DEPTH)-1:0] Occ
`else
  output logic             Q_valid
`endif
);

  if (DEPTH < 1 || DEPTH > REG_PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("reg_pipe: DEPTH must be 1..16");
  end

  if (WIDTH < 1 || WIDTH > REG_PIPE_MAX_WIDTH) begin : g_bad_width
    $error("reg_pipe: WIDTH must be 1..64");
  end

  logic [WIDTH-1:0] data_s  [DEPTH];
  logic             valid_s [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (i == 0) begin : g_head
      assign d_in = D;
      assign v_in = D_valid;
    end else begin : g_tail
      assign d_in = data_s[i-1];
      assign v_in = valid_s[i-1];
    end

    reg_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (En),
      .clr_i    (Clr),
      .d_i      (d_in),
      .d_valid_i(v_in),
      .q_o      (data_s[i]),
      .q_valid_o(valid_s[i])
    );
  end

  assign Q       = data_s[DEPTH-1];
  assign Q_valid = valid_s[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic [OW-1:0] occ_q, occ_d;

  // One word may enter and one leave per advance.
  always_comb begin
    occ_d = occ_q;
    if (Clr) begin
      occ_d = '0;
    end else if (En) begin
      occ_d = occ_q + OW'(D_valid)
            - OW'(valid_s[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign Occ = occ_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: scoreboard bench for reg_pipe (WIDTH=8, DEPTH=3).
// Occ checks are compiled in with REG_PIPE_OCC_EN.
module tb_reg_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] D;
  logic       D_valid;
  logic       En;
  logic       Clr;
  logic [7:0] Q;
  logic       Q_valid;
`ifdef REG_PIPE_OCC_EN
  logic [1:0] Occ;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];
  logic adv;

  always #5 clk = ~clk;

  reg_pipe #(
    .WIDTH(8),
    .DEPTH(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .D      (D),
    .D_valid(D_valid),
    .En     (En),
    .Clr    (Clr),
    .Q      (Q),
`ifdef REG_PIPE_OCC_EN
    .Q_valid(Q_valid),
    .Occ    (Occ)
`else
    .Q_valid(Q_valid)
`endif
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) adv <= 1'b0;
    else        adv <= En && !Clr;
  end

  // Each advancing edge that lands a valid word on Q consumes one entry.
  always @(negedge clk) begin
    if (rst_n && adv && Q_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected got=%0h exp=none", Q);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (Q !== e) begin
          bad++;
          $display("FAIL mon_data got=%0h exp=%0h", Q, e);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_q(input string name,
                       input logic [7:0] q,
                       input logic qv);
    chk({name, "_q"}, 32'(Q), 32'(q));
    chk({name, "_qv"}, 32'(Q_valid), 32'(qv));
  endtask

  task automatic chk_occ(input string name,
                         input int exp);
`ifdef REG_PIPE_OCC_EN
    chk({name, "_occ"}, 32'(Occ), 32'(exp));
`endif
  endtask

  task automatic drive(input logic [7:0] d,
                       input logic dv,
                       input logic en,
                       input logic clr);
    D = d; D_valid = dv; En = en; Clr = clr;
    if (rst_n) begin
      if (clr)            sb.delete();
      else if (en && dv)  sb.push_back(d);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    D = 8'hFF; D_valid = 1'b1;
    En = 1'b1; Clr = 1'b0;
    #1;
    chk_q("rst_t0", 8'h00, 1'b0);
    chk_occ("rst_t0", 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_q("rst_hold", 8'h00, 1'b0);
      chk_occ("rst_hold", 0);
    end
    rst_n = 1'b1;
    drive(8'hFF, 1, 1, 0);
    chk_q("rel_e1", 8'h00, 1'b0);
    chk_occ("rel_e1", 1);
    drive(8'h00, 0, 1, 0);
    drive(8'h00, 0, 1, 0);
    chk_q("rel_e3", 8'hFF, 1'b1);
    chk_occ("rel_e3", 1);
    drive(8'h00, 0, 1, 1);
    chk_q("clr0", 8'h00, 1'b0);
    chk_occ("clr0", 0);

    drive(8'h11, 1, 1, 0);
    chk_q("str_e1", 8'h00, 1'b0);
    drive(8'h22, 1, 1, 0);
    drive(8'h33, 1, 1, 0);
    chk_q("str_e3", 8'h11, 1'b1);
    chk_occ("str_e3", 3);
    drive(8'h00, 0, 1, 0);
    chk_q("str_e4", 8'h22, 1'b1);
    chk_occ("str_e4", 2);
    drive(8'h00, 0, 1, 0);
    chk_q("str_e5", 8'h33, 1'b1);
    chk_occ("str_e5", 1);
    drive(8'h00, 0, 1, 0);
    chk_q("str_e6", 8'h00, 1'b0);
    chk_occ("str_e6", 0);

    drive(8'hA1, 1, 1, 0);
    drive(8'hA2, 1, 1, 0);
    drive(8'h00, 0, 1, 0);
    chk_q("stl_pre", 8'hA1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(8'hEE, 1, 0, 0);
      chk_q("stl_hold", 8'hA1, 1'b1);
      chk_occ("stl_hold", 2);
    end
    drive(8'h00, 0, 1, 0);
    chk_q("stl_res1", 8'hA2, 1'b1);
    drive(8'h00, 0, 1, 0);
    chk_q("stl_res2", 8'h00, 1'b0);
    chk_occ("stl_res2", 0);

    drive(8'h01, 1, 1, 0);
    chk_occ("bub_e1", 1);
    drive(8'h55, 0, 1, 0);
    chk_occ("bub_e2", 1);
    drive(8'h02, 1, 1, 0);
    chk_q("bub_e3", 8'h01, 1'b1);
    chk_occ("bub_e3", 2);
    drive(8'h00, 0, 1, 0);
    chk_q("bub_e4", 8'h55, 1'b0);
    chk_occ("bub_e4", 1);
    drive(8'h00, 0, 1, 0);
    chk_q("bub_e5", 8'h02, 1'b1);
    chk_occ("bub_e5", 1);
    drive(8'h00, 0, 1, 0);
    chk_q("bub_e6", 8'h00, 1'b0);
    chk_occ("bub_e6", 0);

    drive(8'hC1, 1, 1, 0);
    drive(8'hC2, 1, 1, 0);
    drive(8'hC3, 1, 1, 0);
    chk_q("cp_full", 8'hC1, 1'b1);
    chk_occ("cp_full", 3);
    drive(8'h77, 1, 1, 1);
    chk_q("cp_clr", 8'h00, 1'b0);
    chk_occ("cp_clr", 0);
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 0, 1, 0);
      chk_q("cp_after", 8'h00, 1'b0);
    end

    drive(8'hD1, 1, 1, 0);
    drive(8'hD2, 1, 1, 0);
    drive(8'hD3, 1, 1, 0);
    chk_q("ar_full", 8'hD1, 1'b1);
    D = 8'h00; D_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_q("ar_now", 8'h00, 1'b0);
    chk_occ("ar_now", 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 0, 1, 0);
      chk_q("ar_after", 8'h00, 1'b0);
      chk_occ("ar_after", 0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
